dp_test_seq: RTL and testbench

Sequencer and self-checker for the registered test datapath in the prototyping template. On a start pulse it issues a programmable run of incrementing test vectors into the datapath input register, one per clock. It compares every datapath result against the expected value (vector XOR mask) after a fixed pipeline latency, then reports pass/fail, an error count and the first failing index to the VIO or LEDs.

---
 rtl/dp_test_seq.sv | 157 +++++++++++++++
 tb/tb_dp_test_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_test_seq.sv
// dp_test_seq: issues a run of incrementing test vectors into a registered
// datapath and checks each result against vector ^ mask after LATENCY clocks.
// Reports pass/fail, a saturating error count and the first failing index.
// Optional feature macro: DP_SEQ_STOP_ON_ERR_EN (end the run on the first mismatch).
module dp_test_seq #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int VECTORS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] dp_in,
    output logic             dp_vld,
    input  logic [WIDTH-1:0] dp_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One in-flight check: which vector it was and what was driven.
    typedef struct packed {
        logic [15:0]      idx;
        logic [WIDTH-1:0] vec;
    } chk_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [15:0]      LAST_IDX = 16'(VECTORS - 1);
    localparam logic [3:0]       LAST_DRN = 4'(LATENCY - 1);

    state_t             state;
    logic [WIDTH-1:0]   mask_q;
    logic [15:0]        idx_q;
    logic [3:0]         drain_cnt;
    logic [LATENCY-1:0] vld_pipe;
    chk_t               chk_pipe [LATENCY];

    logic mismatch;
    logic abort_run;
    logic stop_hit;

    // Compare the entry leaving the check pipeline against the live datapath output.
    assign mismatch  = vld_pipe[LATENCY-1] &&
                       (dp_out != (chk_pipe[LATENCY-1].vec ^ mask_q));
    assign abort_run = abort && (state != IDLE);

`ifdef DP_SEQ_STOP_ON_ERR_EN
    assign stop_hit = mismatch && !abort_run;
`else
    assign stop_hit = 1'b0;
`endif

    // Check pipeline: delays {valid, index, vector} to line up with dp_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) chk_pipe[i] <= '0;
        end else if (abort_run || stop_hit) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0]     <= dp_vld;
            chk_pipe[0].idx <= idx_q;
            chk_pipe[0].vec <= dp_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                chk_pipe[i] <= chk_pipe[i-1];
            end
        end
    end

    // Run sequencer with registered outputs and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dp_in         <= '0;
            dp_vld        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= 16'hFFFF;
            mask_q        <= '0;
            idx_q         <= '0;
            drain_cnt     <= '0;
        end else begin
            done <= 1'b0;

            // Errors land one cycle after the compare; an abort discards the compare.
            if (mismatch && !abort_run) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (first_err_idx == 16'hFFFF) first_err_idx <= chk_pipe[LATENCY-1].idx;
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        dp_in         <= seed;
                        dp_vld        <= 1'b1;
                        mask_q        <= mask;
                        idx_q         <= '0;
                        err_cnt       <= '0;
                        pass          <= 1'b0;
                        first_err_idx <= 16'hFFFF;
                    end
                end
                RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state     <= DRAIN;
                        dp_vld    <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        dp_in <= dp_in + ONE;
                        idx_q <= idx_q + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRN) begin
                        state <= DONE;
                        done  <= 1'b1;
                        // Include the final compare happening this cycle.
                        pass  <= (err_cnt == 16'd0) && !mismatch;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (abort_run) begin
                state  <= IDLE;
                busy   <= 1'b0;
                dp_vld <= 1'b0;
                pass   <= 1'b0;
                done   <= 1'b0;
            end else if (stop_hit) begin
                state  <= DONE;
                dp_vld <= 1'b0;
                done   <= 1'b1;
                pass   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dp_test_seq.sv
// Scoreboard bench for dp_test_seq: four instances (VECTORS 4/16/8/65535),
// each fed by a two-register datapath model. Stimulus pushes expected vectors
// and done reports into queues; a negedge monitor pops and compares.
module tb_dp_test_seq;

    localparam int W  = 32;
    localparam int L  = 2;
    localparam int NI = 4;

    typedef struct {int inst; int cyc; logic [W-1:0] v;} vexp_t;
    typedef struct {int inst; int cyc; logic p; logic [15:0] ec; logic [15:0] fe;} dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic [NI-1:0] start = '0;
    logic [W-1:0] seed = '0, mask = '0;
    logic [NI-1:0][W-1:0] dp_in, dp_out, d1, d2;
    logic [NI-1:0] dp_vld, busy, done, pass;
    logic [NI-1:0][15:0] err_cnt, first_err_idx;

    int cyc = 0;
    int n_run = 0;
    int n_fail = 0;

    // Datapath model controls (only one instance runs at a time).
    logic stuck = 1'b0;
    logic flip_en = 1'b0;
    logic [W-1:0] xm = '0;
    logic [W-1:0] flip_val = '0;

    vexp_t vq[$];
    dexp_t dq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= dp_in;
        d2  <= d1;
    end

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            assign dp_out[g] = stuck ? '0 :
                (d2[g] ^ xm ^ ((flip_en && d2[g] == flip_val) ? 32'd1 : 32'd0));
            dp_test_seq #(
                .WIDTH(W), .LATENCY(L),
                .VECTORS((g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 8 : 65535)
            ) u_dut (
                .clk(clk), .rst(rst), .start(start[g]), .abort(abort),
                .seed(seed), .mask(mask), .dp_in(dp_in[g]), .dp_vld(dp_vld[g]),
                .dp_out(dp_out[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
                .err_cnt(err_cnt[g]), .first_err_idx(first_err_idx[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input int i);
        chk("rst_dp_in",   dp_in[i],         '0);
        chk("rst_dp_vld",  W'(dp_vld[i]),    '0);
        chk("rst_busy",    W'(busy[i]),      '0);
        chk("rst_done",    W'(done[i]),      '0);
        chk("rst_pass",    W'(pass[i]),      '0);
        chk("rst_err_cnt", W'(err_cnt[i]),   '0);
        chk("rst_first",   W'(first_err_idx[i]), 32'h0000_FFFF);
    endtask

    // Issue a start; push nv expected vectors and (if dc >= 0) a done report at start+dc.
    task automatic run(input int i, input logic [W-1:0] sd, input logic [W-1:0] mk,
                       input int nv, input int dc, input logic p,
                       input logic [15:0] ec, input logic [15:0] fe);
        vexp_t ve;
        dexp_t de;
        seed = sd;
        mask = mk;
        start[i] = 1'b1;
        for (int k = 0; k < nv; k++) begin
            ve.inst = i; ve.cyc = cyc + 1 + k; ve.v = sd + W'(k);
            vq.push_back(ve);
        end
        if (dc >= 0) begin
            de.inst = i; de.cyc = cyc + dc; de.p = p; de.ec = ec; de.fe = fe;
            dq.push_back(de);
        end
        tick;
        start[i] = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then a few more cycles to catch stray reports.
    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((vq.size() != 0 || dq.size() != 0) && n < maxc) begin
            tick;
            n++;
        end
        if (n >= maxc) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout: %0d vectors, %0d reports outstanding", vq.size(), dq.size());
            vq.delete();
            dq.delete();
        end
        repeat (4) tick;
    endtask

    // Monitor: compare every live vector and every done pulse against the queues.
    always @(negedge clk) begin
        vexp_t ve;
        dexp_t de;
        for (int i = 0; i < NI; i++) begin
            if (dp_vld[i] && i != 3) begin
                if (vq.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL unexpected_vec: inst %0d value %h cycle %0d", i, dp_in[i], cyc);
                end else begin
                    ve = vq.pop_front();
                    chk("vec_inst", W'(i), W'(ve.inst));
                    chk("vec_cyc", W'(cyc), W'(ve.cyc));
                    chk("vec_val", dp_in[i], ve.v);
                end
            end
            if (done[i]) begin
                if (dq.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL unexpected_done: inst %0d cycle %0d", i, cyc);
                end else begin
                    de = dq.pop_front();
                    chk("done_inst", W'(i), W'(de.inst));
                    chk("done_cyc", W'(cyc), W'(de.cyc));
                    chk("done_pass", W'(pass[i]), W'(de.p));
                    chk("done_err_cnt", W'(err_cnt[i]), W'(de.ec));
                    chk("done_first", W'(first_err_idx[i]), W'(de.fe));
                end
            end
        end
    end

    initial begin
        repeat (3) tick;
        chk_rst(0);
        chk_rst(3);
        rst = 1'b0;
        tick;

        // Loopback across the wrap point.
        xm = '0;
        run(0, 32'hFFFF_FFFE, '0, 4, 7, 1'b1, 16'd0, 16'hFFFF);
        drain(50);
        chk("pass_held", W'(pass[0]), 32'd1);

        // Datapath XORs with the mask: clean run.
        xm = 32'h0000_00FF;
        run(1, 32'h10, 32'hFF, 16, 19, 1'b1, 16'd0, 16'hFFFF);
        drain(50);

        // Single bit flip on index 5 (vector 0x15).
        flip_en = 1'b1;
        flip_val = 32'h15;
`ifdef DP_SEQ_STOP_ON_ERR_EN
        run(1, 32'h10, 32'hFF, 8, 9, 1'b0, 16'd1, 16'd5);
`else
        run(1, 32'h10, 32'hFF, 16, 19, 1'b0, 16'd1, 16'd5);
`endif
        drain(50);
        flip_en = 1'b0;

        // Stuck-at-zero datapath.
        stuck = 1'b1;
`ifdef DP_SEQ_STOP_ON_ERR_EN
        run(2, 32'h1, '0, 3, 4, 1'b0, 16'd1, 16'd0);
`else
        run(2, 32'h1, '0, 8, 11, 1'b0, 16'd8, 16'd0);
`endif
        drain(50);
        stuck = 1'b0;

        // start and abort together in IDLE: start is dropped.
        start[0] = 1'b1;
        abort = 1'b1;
        tick;
        start[0] = 1'b0;
        abort = 1'b0;
        chk("sa_busy", W'(busy[0]), '0);
        chk("sa_vld", W'(dp_vld[0]), '0);

        // Abort in cycle 3 of a 16-vector run, then a clean rerun.
        xm = 32'h0000_00FF;
        run(1, 32'h20, 32'hFF, 3, -1, 1'b0, 16'd0, 16'd0);
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", W'(busy[1]), '0);
        chk("abort_vld", W'(dp_vld[1]), '0);
        chk("abort_pass", W'(pass[1]), '0);
        drain(50);
        run(1, 32'h20, 32'hFF, 16, 19, 1'b1, 16'd0, 16'hFFFF);
        drain(50);

        // start pulses during RUN and DRAIN are ignored.
        xm = '0;
        run(0, 32'h100, '0, 4, 7, 1'b1, 16'd0, 16'hFFFF);
        tick;
        seed = 32'hDEAD_BEEF;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (3) tick;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        drain(50);

        // rst in cycle 5 of a failing run: reset values in cycle 6.
        stuck = 1'b1;
        run(1, 32'h200, '0, 5, -1, 1'b0, 16'd0, 16'd0);
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_rst(1);
        drain(50);

        // Longest run against constant zero: count tops out at 0xFFFF.
`ifdef DP_SEQ_STOP_ON_ERR_EN
        run(3, 32'h1, '0, 0, 4, 1'b0, 16'd1, 16'd0);
`else
        run(3, 32'h1, '0, 0, 65538, 1'b0, 16'hFFFF, 16'd0);
`endif
        drain(70000);
        stuck = 1'b0;
        chk("sat_err_cnt_hold", W'(err_cnt[3]),
`ifdef DP_SEQ_STOP_ON_ERR_EN
            32'd1);
`else
            32'h0000_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
